// File: rtl/control_compuerta_if.sv
// Gate controller signal bundle: vehicle sensors, PIN entry and gate status.
// The master side (the stimulus) drives the sensors and the PIN keypad; the
// slave side (the controller) drives the gate status lines.
interface control_compuerta_if;
  logic       Vehiculo;
  logic       Termino;
  logic       enterPin;
  logic [7:0] Pin;
  logic       Cerrado;
  logic       Abierto;
  logic       Alarma;
  logic       Bloqueo;

  modport master (
    output Vehiculo, Termino, enterPin, Pin,
    input  Cerrado, Abierto, Alarma, Bloqueo
  );

  modport slave (
    input  Vehiculo, Termino, enterPin, Pin,
    output Cerrado, Abierto, Alarma, Bloqueo
  );
endinterface

// File: rtl/control_compuerta.sv
// Parking-entrance gate controller. Moore FSM with a wrong-PIN attempt counter
// and rising-edge detection on the enter button. Outputs are registered and
// always equal the decode of the state register.
module control_compuerta #(
  parameter logic [7:0] PIN_CORRECTO = 8'b00010000,
  parameter int         MAX_INTENTOS = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  control_compuerta_if.slave bus
);

  typedef enum logic [2:0] {
    CERRADO    = 3'd0,
    ESPERA_PIN = 3'd1,
    ALARMA_PIN = 3'd2,
    ABIERTO    = 3'd3,
    BLOQUEO    = 3'd4
  } estado_t;

  // Threshold widened by one bit so intentos+1 cannot wrap in the compare.
  localparam logic [3:0] MAX_W = 4'(MAX_INTENTOS);

  estado_t    estado, estado_n;
  logic [2:0] intentos, intentos_n, intentos_inc;
  logic       enter_q;
  logic       ent, ok, bad;

  // Output vector order: {Cerrado, Abierto, Alarma, Bloqueo}.
  function automatic logic [3:0] salidas(input estado_t e);
    case (e)
      CERRADO,
      ESPERA_PIN: salidas = 4'b1000;
      ALARMA_PIN: salidas = 4'b1010;
      ABIERTO:    salidas = 4'b0100;
      BLOQUEO:    salidas = 4'b1011;
      default:    salidas = 4'b1000;
    endcase
  endfunction

  // A press is the first cycle enterPin is seen high; Pin is judged at that edge.
  assign ent          = bus.enterPin & ~enter_q;
  assign ok           = ent & (bus.Pin == PIN_CORRECTO);
  assign bad          = ent & (bus.Pin != PIN_CORRECTO);
  assign intentos_inc = (intentos == 3'd7) ? 3'd7 : intentos + 3'd1;

  // Next-state and next-counter logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    estado_n   = estado;
    intentos_n = intentos;
    case (estado)
      CERRADO: begin
        if (bus.Vehiculo) estado_n = ESPERA_PIN;
      end
      ESPERA_PIN: begin
        if (ok) begin
          estado_n = ABIERTO;
        end else if (bad) begin
          intentos_n = intentos_inc;
          if (({1'b0, intentos} + 4'd1) >= MAX_W) estado_n = ALARMA_PIN;
        end else if (!bus.Vehiculo) begin
          estado_n = CERRADO;
        end
      end
      ALARMA_PIN: begin
        if (ok)       estado_n   = ABIERTO;
        else if (bad) intentos_n = intentos_inc;
      end
      ABIERTO: begin
        if (bus.Termino) estado_n = bus.Vehiculo ? BLOQUEO : CERRADO;
      end
      BLOQUEO: begin
        if (ok) estado_n = ABIERTO;
      end
      default: estado_n = CERRADO;
    endcase
    // A correct PIN or a return to idle starts the attempt count afresh.
    if (ok || (estado_n == CERRADO)) intentos_n = 3'd0;
  end

  // State, counter, edge-detect flop and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      estado       <= CERRADO;
      intentos     <= 3'd0;
      // Starting high means a button already held at release is not a press.
      enter_q      <= 1'b1;
      bus.Cerrado  <= 1'b1;
      bus.Abierto  <= 1'b0;
      bus.Alarma   <= 1'b0;
      bus.Bloqueo  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      estado   <= estado_n;
      intentos <= intentos_n;
      enter_q  <= bus.enterPin;
      {bus.Cerrado, bus.Abierto, bus.Alarma, bus.Bloqueo} <= salidas(estado_n);
    end
  end

endmodule

// File: doc/control_compuerta.md
# control_compuerta

Gate controller for the parking-entrance subsystem: the design unit that the gate stimulus bench drives. It accepts a vehicle-present sensor, an 8-bit PIN with an enter button and a vehicle-passed sensor. It produces the gate state (closed/open), an alarm and a block indication. It is a single Moore FSM with a wrong-PIN attempt counter and enter-button edge detection.

## Interface
- PIN_CORRECTO, 8'b00010000, PIN value that opens the gate
- MAX_INTENTOS, 3, number of consecutive wrong PINs that raises the PIN alarm (1..7)
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- Vehiculo  input  1  vehicle present at the gate sensor (level)
- Termino  input  1  vehicle finished passing (pulse, nominally one cycle)
- enterPin  input  1  enter button (level; acted on at its rising edge only)
- Pin  input  8  PIN value, sampled on the enter rising edge
- Cerrado  output  1  gate closed
- Abierto  output  1  gate open
- Alarma  output  1  alarm (wrong-PIN or block)
- Bloqueo  output  1  gate blocked (tailgating detected)

## Operation
- States: CERRADO (idle), ESPERA_PIN, ALARMA_PIN, ABIERTO, BLOQUEO; 3-bit encoding.
- Output decode:
  - CERRADO and ESPERA_PIN: Cerrado=1.
  - ALARMA_PIN: Cerrado=1, Alarma=1.
  - ABIERTO: Abierto=1.
  - BLOQUEO: Cerrado=1, Alarma=1, Bloqueo=1.
  - All outputs not listed for a state are 0.
- Edge detect:
  - enter_q <= enterPin each cycle.
  - ent = enterPin & ~enter_q.
  - ok = ent & (Pin == PIN_CORRECTO).
  - bad = ent & (Pin != PIN_CORRECTO).
- Attempt counter intentos: 3 bits, saturates at 7. It clears on every ok and on entering CERRADO.
- CERRADO:
  - Vehiculo=1 goes to ESPERA_PIN.
  - enterPin and Termino are ignored.
- ESPERA_PIN:
  - ok goes to ABIERTO.
  - bad increments intentos. If intentos+1 >= MAX_INTENTOS, go to ALARMA_PIN; otherwise stay.
  - Vehiculo=0 with no ent goes to CERRADO.
- ALARMA_PIN:
  - Exits only on ok, to ABIERTO, which also clears Alarma.
  - bad increments intentos (saturating).
  - Vehiculo dropping does not clear the alarm.
- ABIERTO:
  - Termino=1 with Vehiculo=1 goes to BLOQUEO (tailgating).
  - Termino=1 with Vehiculo=0 goes to CERRADO.
  - enterPin is ignored.
- BLOQUEO:
  - Exits only on ok, to ABIERTO.
  - bad is ignored and intentos is unchanged.
  - Termino and Vehiculo are ignored.
- Pin changes without an enter rising edge never affect state or counter.
- Holding enterPin high counts as one attempt only.

## Timing
- Reset (async assert) forces:
  - state=CERRADO, intentos=0, enter_q=1.
  - Outputs Cerrado=1, Abierto=0, Alarma=0, Bloqueo=0, effective immediately.
- enter_q resets to 1, so an enterPin already high when Reset releases is not treated as a press.
- Reset dominates every other input, including all inputs high with the correct PIN.
- Inputs are sampled at the rising Clk edge; no input synchronizers (inputs are synchronous to Clk).
- Outputs are a pure decode of the state register. They change after the edge at which the triggering input is sampled (latency 1 edge, no extra pipeline).
- ent is valid in the cycle where enterPin is first sampled high. Pin must be stable at that same edge.
- Minimum enterPin low time between presses: 1 cycle.
- Simultaneous ok and Vehiculo=0 in ESPERA_PIN: ok wins, go to ABIERTO.
- Bench clock: 40 time-unit period; input changes occur mid-cycle.

## Test plan
- Normal entry: Reset pulse, Vehiculo=1, enter with Pin=8'h10 -> Abierto=1 next edge. Then Vehiculo=0 with Termino=1 for 1 cycle -> Cerrado=1, Abierto=0.
- Wrong-PIN alarm: Vehiculo=1, three enter presses with Pin=8'hFF -> Alarma=1 after the 3rd, Cerrado=1. Fourth wrong press -> Alarma stays 1. Pin=8'h10 press -> Abierto=1, Alarma=0.
- Below threshold: one wrong press -> Alarma stays 0. Correct press -> Abierto=1, and intentos reads 0.
- Block: in ABIERTO drive Vehiculo=1 with Termino=1 -> Bloqueo=1, Alarma=1, Cerrado=1. Wrong press -> unchanged. Correct press -> Abierto=1, Bloqueo=0. Termino with Vehiculo=0 -> Cerrado.
- Enter gating: in ESPERA_PIN sweep Pin 8'h00 then 8'h10 for 2 cycles each with enterPin=0 -> no output change. enterPin held high 3 cycles with Pin=8'h10 -> single transition to ABIERTO.
- Reset mid-operation: from BLOQUEO, ABIERTO and CERRADO, assert Reset with Vehiculo=Termino=enterPin=1 and Pin=8'h10 -> Cerrado=1, all others 0 asynchronously. Release with enterPin=1 held -> no attempt counted.
